// File: rtl/upstream_risk_engine_pkg.sv
// ----------------------------------------------------------------------------
// upstream_risk_pkg
//   Shared types for the upstream pre-trade risk engine: command opcodes,
//   response codes, the default client table entry layout and the FSM states.
//   No ports; imported by the interface-using modules.
// ----------------------------------------------------------------------------
package upstream_risk_pkg;

  // Default amount width; the engine builds its own entry type when AMT_W
  // is overridden, this layout is what the table uses out of the box.
  localparam int RISK_AMT_W = 16;

  typedef enum logic [1:0] {
    OP_NEW_ORDER = 2'd0,
    OP_SET_MAX   = 2'd1,
    OP_CANCEL    = 2'd2,
    OP_RSVD      = 2'd3
  } risk_op_e;

  typedef enum logic [1:0] {
    CODE_OK      = 2'd0,
    CODE_LIMIT   = 2'd1,
    CODE_BAD_REQ = 2'd2
  } risk_code_e;

  typedef struct packed {
    logic [RISK_AMT_W-1:0] max;
    logic [RISK_AMT_W-1:0] exp;
  } risk_entry_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_RESP
  } risk_state_e;

endpackage

// File: rtl/upstream_risk_engine_if.sv
// ----------------------------------------------------------------------------
// upstream_risk_engine_if
//   Command / response channels of the risk engine, both valid/ready.
//   master : order sender (drives req_*, rsp_ready)
//   slave  : risk engine  (drives req_ready, rsp_*)
//   req_op 2b, req_client CLIENT_W, req_amount AMT_W
//   rsp_code 2b, rsp_client CLIENT_W, rsp_exposure AMT_W
// ----------------------------------------------------------------------------
interface upstream_risk_engine_if #(
  parameter int CLIENT_W = 5,
  parameter int AMT_W    = 16
);
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  logic [CLIENT_W-1:0] req_client;
  logic [AMT_W-1:0]    req_amount;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_code;
  logic [CLIENT_W-1:0] rsp_client;
  logic [AMT_W-1:0]    rsp_exposure;

  modport master (
    output req_valid, req_op, req_client, req_amount, rsp_ready,
    input  req_ready, rsp_valid, rsp_code, rsp_client, rsp_exposure
  );

  modport slave (
    input  req_valid, req_op, req_client, req_amount, rsp_ready,
    output req_ready, rsp_valid, rsp_code, rsp_client, rsp_exposure
  );
endinterface

// File: rtl/upstream_risk_engine_table.sv
// ----------------------------------------------------------------------------
// risk_table
//   Per-client {max, exp} storage: N_CLIENTS entries, one registered read port
//   and one write port. No reset on the array so it can map onto block RAM;
//   the engine clears it with its INIT sweep instead.
//   clk      in   clock
//   rd_en    in   load rd_data from mem[rd_addr] on this edge
//   rd_addr  in   read index
//   rd_data  out  registered read data
//   wr_en    in   write enable
//   wr_addr  in   write index
//   wr_data  in   write data
// ----------------------------------------------------------------------------
module risk_table
  import upstream_risk_pkg::*;
#(
  parameter int  N_CLIENTS = 32,
  parameter int  CLIENT_W  = $clog2(N_CLIENTS),
  parameter type entry_t   = risk_entry_t
) (
  input  logic                clk,
  input  logic                rd_en,
  input  logic [CLIENT_W-1:0] rd_addr,
  output entry_t              rd_data,
  input  logic                wr_en,
  input  logic [CLIENT_W-1:0] wr_addr,
  input  entry_t              wr_data
);

  entry_t mem [N_CLIENTS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/upstream_risk_engine.sv
// ----------------------------------------------------------------------------
// upstream_risk_engine
//   Pre-trade risk engine. Holds a per-client limit (max) and accumulated
//   exposure (exp); serves one command at a time: NEW_ORDER is granted only
//   if exp + amount stays strictly below max, SET_MAX replaces the limit,
//   CANCEL lowers exposure with a floor at zero.
//   clk          in   clock
//   HRESETn      in   synchronous active-low reset
//   bus          if   slave side of upstream_risk_engine_if
//   stat_accept  out  granted orders, saturating
//   stat_reject  out  LIMIT-rejected orders, saturating
// ----------------------------------------------------------------------------
module upstream_risk_engine
  import upstream_risk_pkg::*;
#(
  parameter int N_CLIENTS = 32,
  parameter int CLIENT_W  = $clog2(N_CLIENTS),
  parameter int AMT_W     = 16,
  parameter int STAT_W    = 16
) (
  input  logic                  clk,
  input  logic                  HRESETn,
  upstream_risk_engine_if.slave bus,
  output logic [STAT_W-1:0]     stat_accept,
  output logic [STAT_W-1:0]     stat_reject
);

  typedef struct packed {
    logic [AMT_W-1:0] max;
    logic [AMT_W-1:0] exp;
  } entry_t;

  // Compared one bit wider so a power-of-two table does not yield a
  // constant-false comparison.
  localparam logic [CLIENT_W:0]   CLIENT_LIMIT = (CLIENT_W+1)'(N_CLIENTS);
  localparam logic [CLIENT_W-1:0] INIT_LAST    = CLIENT_W'(N_CLIENTS - 1);

  risk_state_e         state_reg;
  logic [CLIENT_W-1:0] init_idx_reg;

  risk_op_e            cmd_op_reg;
  logic [CLIENT_W-1:0] cmd_client_reg;
  logic [AMT_W-1:0]    cmd_amount_reg;
  logic                cmd_bad_reg;

  logic                req_ready_reg;
  logic                rsp_valid_reg;
  risk_code_e          rsp_code_reg;
  logic [CLIENT_W-1:0] rsp_client_reg;
  logic [AMT_W-1:0]    rsp_exposure_reg;
  logic [STAT_W-1:0]   stat_accept_reg;
  logic [STAT_W-1:0]   stat_reject_reg;

  // Table ports
  entry_t              rd_data;
  logic                tbl_rd_en;
  logic                tbl_wr_en;
  logic [CLIENT_W-1:0] tbl_wr_addr;
  entry_t              tbl_wr_data;

  // EXEC-stage result
  entry_t              cur_entry;
  entry_t              new_entry;
  logic [AMT_W:0]      order_sum;
  logic                order_ok;
  logic                is_order;
  logic                need_write;
  risk_code_e          res_code;
  logic [AMT_W-1:0]    res_exposure;

  logic                req_fire;
  logic                req_bad;

  assign req_fire = bus.req_valid && req_ready_reg;
  assign req_bad  = (risk_op_e'(bus.req_op) == OP_RSVD) ||
                    ({1'b0, bus.req_client} >= CLIENT_LIMIT);

  // --------------------------------------------------------------------------
  // Command evaluation against the entry read in READ.
  // --------------------------------------------------------------------------
  always_comb begin
    cur_entry  = rd_data;
    // One extra bit so a large order cannot wrap around and look acceptable.
    order_sum  = {1'b0, cur_entry.exp} + {1'b0, cmd_amount_reg};
    order_ok   = order_sum < {1'b0, cur_entry.max};
    new_entry  = cur_entry;
    res_code   = CODE_OK;
    need_write = 1'b0;
    is_order   = 1'b0;
    if (cmd_bad_reg) begin
      res_code = CODE_BAD_REQ;
    end else begin
      case (cmd_op_reg)
        OP_NEW_ORDER: begin
          is_order = 1'b1;
          if (order_ok) begin
            new_entry.exp = order_sum[AMT_W-1:0];
            need_write    = 1'b1;
          end else begin
            res_code = CODE_LIMIT;
          end
        end
        OP_SET_MAX: begin
          new_entry.max = cmd_amount_reg;
          need_write    = 1'b1;
        end
        OP_CANCEL: begin
          new_entry.exp = (cmd_amount_reg >= cur_entry.exp) ? '0
                                                            : cur_entry.exp - cmd_amount_reg;
          need_write    = 1'b1;
        end
        default: res_code = CODE_BAD_REQ;
      endcase
    end
    res_exposure = (res_code == CODE_BAD_REQ) ? '0 : new_entry.exp;
  end

  // --------------------------------------------------------------------------
  // Table access. Writes are gated by HRESETn so a reset landing on EXEC
  // leaves the entry untouched.
  // --------------------------------------------------------------------------
  assign tbl_rd_en   = (state_reg == ST_READ);
  assign tbl_wr_en   = HRESETn &&
                       ((state_reg == ST_INIT) || ((state_reg == ST_EXEC) && need_write));
  assign tbl_wr_addr = (state_reg == ST_INIT) ? init_idx_reg : cmd_client_reg;
  assign tbl_wr_data = (state_reg == ST_INIT) ? '0 : new_entry;

  risk_table #(
    .N_CLIENTS (N_CLIENTS),
    .CLIENT_W  (CLIENT_W),
    .entry_t   (entry_t)
  ) u_table (
    .clk     (clk),
    .rd_en   (tbl_rd_en),
    .rd_addr (cmd_client_reg),
    .rd_data (rd_data),
    .wr_en   (tbl_wr_en),
    .wr_addr (tbl_wr_addr),
    .wr_data (tbl_wr_data)
  );

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!HRESETn) begin
      state_reg        <= ST_INIT;
      init_idx_reg     <= '0;
      cmd_op_reg       <= OP_NEW_ORDER;
      cmd_client_reg   <= '0;
      cmd_amount_reg   <= '0;
      cmd_bad_reg      <= 1'b0;
      req_ready_reg    <= 1'b0;
      rsp_valid_reg    <= 1'b0;
      rsp_code_reg     <= CODE_OK;
      rsp_client_reg   <= '0;
      rsp_exposure_reg <= '0;
      stat_accept_reg  <= '0;
      stat_reject_reg  <= '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          init_idx_reg <= init_idx_reg + CLIENT_W'(1);
          if (init_idx_reg == INIT_LAST) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_fire) begin
            cmd_op_reg     <= risk_op_e'(bus.req_op);
            cmd_client_reg <= bus.req_client;
            cmd_amount_reg <= bus.req_amount;
            cmd_bad_reg    <= req_bad;
            req_ready_reg  <= 1'b0;
            state_reg      <= ST_READ;
          end
        end
        ST_READ: begin
          state_reg <= ST_EXEC;
        end
        ST_EXEC: begin
          rsp_code_reg     <= res_code;
          rsp_client_reg   <= cmd_client_reg;
          rsp_exposure_reg <= res_exposure;
          if (is_order) begin
            if (order_ok) begin
              if (stat_accept_reg != '1) stat_accept_reg <= stat_accept_reg + STAT_W'(1);
            end else begin
              if (stat_reject_reg != '1) stat_reject_reg <= stat_reject_reg + STAT_W'(1);
            end
          end
          state_reg <= ST_RESP;
        end
        ST_RESP: begin
          // First RESP cycle raises rsp_valid; the payload was loaded in EXEC
          // and stays put until the consumer takes it.
          if (!rsp_valid_reg) begin
            rsp_valid_reg <= 1'b1;
          end else if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_reg;
  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_code     = rsp_code_reg;
  assign bus.rsp_client   = rsp_client_reg;
  assign bus.rsp_exposure = rsp_exposure_reg;
  assign stat_accept      = stat_accept_reg;
  assign stat_reject      = stat_reject_reg;

endmodule
